data_mem_unit: RTL and testbench

//  Data memory stage downstream of the ALU/address path. Consumes Mem_addr_out,
//  RS2_data_out, read_en/write_en and Funct3; produces dmu_out_data for RD write-back.

---
 rtl/data_mem_unit_if.sv | 28 ++
 rtl/data_mem_unit.sv | 169 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the core and the data memory stage.
`default_nettype none

interface data_mem_unit_if #(
  parameter int WIDTH = 32
);
  logic             read_en;
  logic             write_en;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] Mem_addr_out;
  logic [WIDTH-1:0] RS2_data_out;
  logic [WIDTH-1:0] dmu_out_data;
  logic             dmu_busy;
  logic             dmu_valid;
  logic             misalign_err;

  modport master (
    output read_en, write_en, Funct3, Mem_addr_out, RS2_data_out,
    input  dmu_out_data, dmu_busy, dmu_valid, misalign_err
  );

  modport slave (
    input  read_en, write_en, Funct3, Mem_addr_out, RS2_data_out,
    output dmu_out_data, dmu_busy, dmu_valid, misalign_err
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_unit.sv
// data_mem_unit: word RAM with byte/half/word lane steering and a busy/valid handshake.
// Optional macro DMU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning.
`default_nettype none

module data_mem_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input wire             clk,
  input wire             rst,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             is_store_q;
  logic             legal_q;
  logic [AW+1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             f3_ok;
  logic             align_bad;
  logic             legal_d;
  logic [AW+1:0]    eff_addr;
  logic             ram_we;
  logic [3:0]       ram_be;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] rd_shifted;
  logic [WIDTH-1:0] load_ext;
  logic [4:0]       lane_sh;
  logic             w_unused;

  assign w_unused = ^bus.Mem_addr_out[WIDTH-1:AW+2];

  assign accept = (state_q == S_IDLE) && (bus.read_en || bus.write_en);

  // Request classification; when write_en is present the request is a store.
  always_comb begin
    f3_ok     = 1'b0;
    align_bad = 1'b0;
    eff_addr  = bus.Mem_addr_out[AW+1:0];
    if (bus.write_en) begin
      f3_ok = (bus.Funct3 == 3'd0) || (bus.Funct3 == 3'd1) || (bus.Funct3 == 3'd2);
    end else begin
      f3_ok = (bus.Funct3 == 3'd0) || (bus.Funct3 == 3'd1) || (bus.Funct3 == 3'd2) ||
              (bus.Funct3 == 3'd4) || (bus.Funct3 == 3'd5);
    end
    if (bus.Funct3[1:0] == 2'b01) begin
      align_bad   = bus.Mem_addr_out[0];
      eff_addr[0] = 1'b0;
    end else if (bus.Funct3[1:0] == 2'b10) begin
      align_bad     = (bus.Mem_addr_out[1:0] != 2'b00);
      eff_addr[1:0] = 2'b00;
    end
`ifdef DMU_MISALIGN_TRAP_EN
    legal_d = f3_ok && !align_bad;
`else
    legal_d = f3_ok && (align_bad || !align_bad);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      legal_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= 3'd0;
      rdata_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (accept) begin
        is_store_q <= bus.write_en;
        legal_q    <= legal_d;
        addr_q     <= eff_addr;
        wdata_q    <= bus.RS2_data_out;
        f3_q       <= bus.Funct3;
      end
      if (state_q == S_READ) begin
        rdata_q <= mem_q[addr_q[AW+1:2]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.write_en)     state_d = S_WRITE;
        else if (bus.read_en) state_d = S_READ;
      end
      S_READ:  state_d = S_DONE;
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lane_sh    = {addr_q[1:0], 3'b000};
  assign rd_shifted = rdata_q >> lane_sh;

  always_comb begin
    ram_we    = (state_q == S_WRITE) && legal_q;
    ram_be    = 4'b0000;
    ram_wdata = wdata_q;
    load_ext  = rdata_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    out_d     = out_q;
    case (f3_q[1:0])
      2'b00: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
    case (f3_q)
      3'd0:    load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'd1:    load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'd4:    load_ext = {24'd0, rd_shifted[7:0]};
      3'd5:    load_ext = {16'd0, rd_shifted[15:0]};
      default: load_ext = rdata_q;
    endcase
    if (state_q == S_DONE) begin
      valid_d = 1'b1;
      err_d   = !legal_q;
      if (!is_store_q && legal_q) out_d = load_ext;
    end
  end

  // RAM is intentionally not reset; writes only occur on the WRITE-state edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem_q[addr_q[AW+1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  assign bus.dmu_out_data = out_q;
  assign bus.dmu_busy     = (state_q != S_IDLE);
  assign bus.dmu_valid    = valid_q;
  assign bus.misalign_err = err_q;
endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: driver queues expectations, monitor checks on dmu_valid.
`default_nettype none

module tb_data_mem_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_unit_if #(.WIDTH(32)) bus ();

  data_mem_unit #(.WIDTH(32), .DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] held     = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.dmu_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("out_data", bus.dmu_out_data, e.d);
        check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.e});
        check("latency", 32'(cyc), 32'(e.acc + 2));
      end
    end
  end

  task automatic clear_inputs();
    bus.read_en      = 1'b0;
    bus.write_en     = 1'b0;
    bus.Funct3       = 3'd0;
    bus.Mem_addr_out = 32'h0;
    bus.RS2_data_out = 32'h0;
  endtask

  task automatic issue(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, input bit poke);
    exp_t e;
    bus.write_en     = we;
    bus.read_en      = re;
    bus.Funct3       = f3;
    bus.Mem_addr_out = a;
    bus.RS2_data_out = d;
    @(posedge clk); #1;
    e.d = exp_d; e.e = exp_e; e.acc = cyc;
    sbq.push_back(e);
    check("busy_after_accept", {31'd0, bus.dmu_busy}, 32'd1);
    clear_inputs();
    if (poke) begin
      bus.write_en     = 1'b1;
      bus.Funct3       = 3'd2;
      bus.Mem_addr_out = 32'h30;
      bus.RS2_data_out = 32'h11111111;
    end
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_d,
                    input logic err);
    issue(1'b0, 1'b1, f3, a, 32'h0, err ? held : exp_d, err, 1'b0);
    if (!err) held = exp_d;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                    input logic err);
    issue(1'b1, 1'b0, f3, a, d, held, err, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"},  bus.dmu_out_data, 32'h0);
    check({tag, "_busy"},  {31'd0, bus.dmu_busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.dmu_valid}, 32'd0);
    check({tag, "_err"},   {31'd0, bus.misalign_err}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #2;
    check_idle_outputs("rst_idle");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Abort a load in flight; no valid may follow.
    bus.read_en = 1'b1; bus.Funct3 = 3'd2; bus.Mem_addr_out = 32'h10;
    @(posedge clk); #1;
    clear_inputs();
    check("midread_busy_before", {31'd0, bus.dmu_busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst_midread");
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    st(3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    ld(3'd2, 32'h10, 32'hDEADBEEF, 1'b0);

    st(3'd2, 32'h10, 32'h0, 1'b0);
    st(3'd0, 32'h13, 32'h00000080, 1'b0);
    ld(3'd0, 32'h13, 32'hFFFFFF80, 1'b0);
    ld(3'd4, 32'h13, 32'h00000080, 1'b0);
    ld(3'd2, 32'h10, 32'h80000000, 1'b0);

    st(3'd2, 32'h20, 32'h0, 1'b0);
    st(3'd1, 32'h22, 32'h00001234, 1'b0);
    ld(3'd5, 32'h22, 32'h00001234, 1'b0);
    ld(3'd1, 32'h20, 32'h00000000, 1'b0);
    ld(3'd2, 32'h20, 32'h12340000, 1'b0);

`ifdef DMU_MISALIGN_TRAP_EN
    ld(3'd2, 32'h11, 32'h0, 1'b1);
`else
    ld(3'd2, 32'h11, 32'h80000000, 1'b0);
`endif

    st(3'd1, 32'h40, 32'h00008001, 1'b0);
    ld(3'd1, 32'h40, 32'hFFFF8001, 1'b0);
    ld(3'd5, 32'h40, 32'h00008001, 1'b0);
`ifdef DMU_MISALIGN_TRAP_EN
    ld(3'd1, 32'h41, 32'h0, 1'b1);
`else
    ld(3'd1, 32'h41, 32'hFFFF8001, 1'b0);
`endif

    // Simultaneous load+store resolves to the store; a request while busy is dropped.
    issue(1'b1, 1'b1, 3'd2, 32'h30, 32'hCAFEF00D, held, 1'b0, 1'b1);
    ld(3'd2, 32'h30, 32'hCAFEF00D, 1'b0);

    st(3'd2, 32'h1010, 32'hA5A5A5A5, 1'b0);
    ld(3'd2, 32'h10, 32'hA5A5A5A5, 1'b0);

    ld(3'd3, 32'h10, 32'h0, 1'b1);
    st(3'd4, 32'h10, 32'hFFFFFFFF, 1'b1);
    ld(3'd2, 32'h10, 32'hA5A5A5A5, 1'b0);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
